mem_stage: RTL and testbench

Pipeline MEM stage, directly upstream of `mem_buffer`. Converts EX/MEM load/store instructions into `mem_buffer` width-coded read/write requests and holds each request until the buffer completes it. Sign-extends load data, stalls the pipeline while an access is in flight, and registers the MEM/WB result. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_stage.sv | 151 +++++++++++++++
 tb/tb_mem_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage that issues width-coded load/store requests to mem_buffer and registers the MEM/WB result.
// Latency: 1 cycle for non-memory instructions; buffer latency + 1 for loads/stores.
// Backpressure: stall_req holds IF/ID/EX while an access is pending; the request is held until the buffer acks.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   ex_*                - EX/MEM instruction fields (must stay stable while stall_req = 1)
//   mem_read_req/mem_write_req/mem_addr/mem_write_data - registered request to mem_buffer
//   mem_data_i, mem_data_enable - zero-extended load data and one-cycle completion pulse
//   stall_req           - combinational pipeline hold
//   wb_*                - MEM/WB register
module mem_stage #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_store_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_wreg,
    input  logic [31:0]       ex_wdata,
    output logic [1:0]        mem_read_req,
    output logic [1:0]        mem_write_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_data_i,
    input  logic              mem_data_enable,
    output logic              stall_req,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_wreg,
    output logic [31:0]       wb_wdata
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q;
    logic [1:0]          read_req_q;
    logic [1:0]          write_req_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         write_data_q;
    logic                wb_valid_q;
    logic [4:0]          wb_rd_q;
    logic                wb_wreg_q;
    logic [31:0]         wb_wdata_q;

    logic                is_mem;
    logic [1:0]          width_code;
    logic [31:0]         load_ext_d;
    logic                ack;

    // Address bits above the RAM window are not routed to the buffer.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^ex_addr[31:ADDR_W];

    assign is_mem    = ex_valid & (ex_is_load | ex_is_store);
    assign ack       = (state_q == BUSY) & mem_data_enable;
    // Releasing the stall on the ack cycle lets upstream advance on the completion edge,
    // so the next instruction is decoded in IDLE and a memory op is never issued twice.
    assign stall_req = is_mem & ~ack;

    always_comb begin
        case (ex_funct3[1:0])
            2'b00:   width_code = 2'b01;
            2'b01:   width_code = 2'b10;
            default: width_code = 2'b11;
        endcase
    end

    always_comb begin
        case (ex_funct3)
            3'b000:  load_ext_d = {{24{mem_data_i[7]}}, mem_data_i[7:0]};
            3'b001:  load_ext_d = {{16{mem_data_i[15]}}, mem_data_i[15:0]};
            3'b100:  load_ext_d = {24'h0, mem_data_i[7:0]};
            3'b101:  load_ext_d = {16'h0, mem_data_i[15:0]};
            default: load_ext_d = mem_data_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            read_req_q   <= 2'b00;
            write_req_q  <= 2'b00;
            addr_q       <= '0;
            write_data_q <= 32'h0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_wreg_q    <= 1'b0;
            wb_wdata_q   <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_mem) begin
                        // Load wins when both load and store are flagged.
                        read_req_q   <= ex_is_load ? width_code : 2'b00;
                        write_req_q  <= ex_is_load ? 2'b00 : width_code;
                        addr_q       <= ex_addr[ADDR_W-1:0];
                        write_data_q <= ex_store_data;
                        wb_valid_q   <= 1'b0;
                        state_q      <= BUSY;
                    end else if (ex_valid) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= ex_rd;
                        wb_wreg_q  <= ex_wreg;
                        wb_wdata_q <= ex_wdata;
                    end else begin
                        wb_valid_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_data_enable) begin
                        // Clearing here keeps the buffer from re-issuing when it returns to fetch.
                        read_req_q  <= 2'b00;
                        write_req_q <= 2'b00;
                        wb_valid_q  <= 1'b1;
                        wb_rd_q     <= ex_rd;
                        // The latched request decides load vs store: it is what the buffer served.
                        if (read_req_q != 2'b00) begin
                            wb_wreg_q  <= ex_wreg;
                            wb_wdata_q <= load_ext_d;
                        end else begin
                            wb_wreg_q  <= 1'b0;
                        end
                        state_q <= IDLE;
                    end else begin
                        wb_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_read_req   = read_req_q;
    assign mem_write_req  = write_req_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = write_data_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd          = wb_rd_q;
    assign wb_wreg        = wb_wreg_q;
    assign wb_wdata       = wb_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage with a table of directed ops plus random ops.
// Latency: the bench plays the buffer, acking each request after a chosen number of cycles.
// Backpressure: EX inputs are held while stall_req is expected high.
module tb_mem_stage;

    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid, ex_is_load, ex_is_store, ex_wreg;
    logic [2:0]        ex_funct3;
    logic [31:0]       ex_addr, ex_store_data, ex_wdata;
    logic [4:0]        ex_rd;
    logic [1:0]        mem_read_req, mem_write_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data, mem_data_i;
    logic              mem_data_enable, stall_req;
    logic              wb_valid, wb_wreg;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_wdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_data_i(mem_data_i), .mem_data_enable(mem_data_enable),
        .stall_req(stall_req),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
    );

    typedef struct {
        logic        valid;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        wreg;
        logic [31:0] alu;
        logic [31:0] rdata;
        int          lat;
        logic [1:0]  e_rreq;
        logic [1:0]  e_wreq;
        logic        e_wreg;
        logic [31:0] e_wdata;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    // A read and a write request never coexist, and a request is never live alongside a valid result.
    task automatic invariants();
        chk("rd_wr_exclusive", {31'h0, (mem_read_req != 2'b00) && (mem_write_req != 2'b00)}, 32'h0);
        chk("req_vs_wb_valid", {31'h0, ((mem_read_req | mem_write_req) != 2'b00) && wb_valid}, 32'h0);
    endtask

    // Reference model: width code from the access size, extension by arithmetic.
    function automatic logic [1:0] model_width(input logic [2:0] f3);
        int bytes;
        bytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        return (bytes == 1) ? 2'b01 : (bytes == 2) ? 2'b10 : 2'b11;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] v;
        case (f3)
            3'd0: begin v = d % 256;   if (v >= 128)   v = v - 32'd256;   end
            3'd1: begin v = d % 65536; if (v >= 32768) v = v - 32'd65536; end
            3'd4: v = d % 256;
            3'd5: v = d % 65536;
            default: v = d;
        endcase
        return v;
    endfunction

    task automatic do_op(input vec_t v);
        logic mem;
        mem = v.valid && (v.ld || v.st);
        ex_valid = v.valid; ex_is_load = v.ld; ex_is_store = v.st; ex_funct3 = v.f3;
        ex_addr = v.addr; ex_store_data = v.sdata; ex_rd = v.rd; ex_wreg = v.wreg; ex_wdata = v.alu;
        #1;
        chk("stall_on_present", {31'h0, stall_req}, {31'h0, mem});
        @(posedge clk); #1;
        if (!mem) begin
            chk("alu_wb_valid", {31'h0, wb_valid}, {31'h0, v.valid});
            if (v.valid) begin
                chk("alu_wb_rd", {27'h0, wb_rd}, {27'h0, v.rd});
                chk("alu_wb_wreg", {31'h0, wb_wreg}, {31'h0, v.wreg});
                chk("alu_wb_wdata", wb_wdata, v.alu);
            end
            chk("alu_no_req", {28'h0, mem_read_req, mem_write_req}, 32'h0);
            chk("alu_no_stall", {31'h0, stall_req}, 32'h0);
        end else begin
            chk("issue_wb_valid", {31'h0, wb_valid}, 32'h0);
            chk("issue_rreq", {30'h0, mem_read_req}, {30'h0, v.e_rreq});
            chk("issue_wreq", {30'h0, mem_write_req}, {30'h0, v.e_wreq});
            chk("issue_addr", {15'h0, mem_addr}, v.addr & 32'h1FFFF);
            if (v.e_wreq != 2'b00) chk("issue_wdata", mem_write_data, v.sdata);
            for (int k = 1; k < v.lat; k++) begin
                chk("busy_stall", {31'h0, stall_req}, 32'h1);
                chk("busy_hold_req", {28'h0, mem_read_req, mem_write_req}, {28'h0, v.e_rreq, v.e_wreq});
                chk("busy_wb_valid", {31'h0, wb_valid}, 32'h0);
                invariants();
                @(posedge clk); #1;
            end
            mem_data_enable = 1'b1;
            mem_data_i = v.rdata;
            #1;
            chk("ack_stall_released", {31'h0, stall_req}, 32'h0);
            chk("ack_req_held", {28'h0, mem_read_req, mem_write_req}, {28'h0, v.e_rreq, v.e_wreq});
            @(posedge clk); #1;
            mem_data_enable = 1'b0;
            mem_data_i = 32'h0;
            chk("done_wb_valid", {31'h0, wb_valid}, 32'h1);
            chk("done_wb_rd", {27'h0, wb_rd}, {27'h0, v.rd});
            chk("done_wb_wreg", {31'h0, wb_wreg}, {31'h0, v.e_wreg});
            if (v.e_rreq != 2'b00) chk("done_wb_wdata", wb_wdata, v.e_wdata);
            chk("done_req_clear", {28'h0, mem_read_req, mem_write_req}, 32'h0);
        end
        invariants();
    endtask

    vec_t tbl[15];

    initial begin
        vec_t r;
        int kind;
        logic [2:0] f3s_ld [6];
        logic [2:0] f3s_st [3];

        //          vld ld st f3    addr           sdata          rd     wr alu            rdata          lat rreq   wreq   ewr e_wdata
        tbl[0]  = '{1, 0, 0, 3'd0, 32'h0,         32'h0,         5'd5,  1, 32'h1234,     32'h0,         1,  2'b00, 2'b00, 1, 32'h1234};
        tbl[1]  = '{1, 1, 0, 3'd0, 32'h100,       32'h0,         5'd6,  1, 32'h0,        32'hF0,        5,  2'b01, 2'b00, 1, 32'hFFFFFFF0};
        tbl[2]  = '{1, 1, 0, 3'd4, 32'h100,       32'h0,         5'd7,  1, 32'h0,        32'hF0,        5,  2'b01, 2'b00, 1, 32'h000000F0};
        tbl[3]  = '{1, 1, 0, 3'd1, 32'h202,       32'h0,         5'd8,  1, 32'h0,        32'h8001,      2,  2'b10, 2'b00, 1, 32'hFFFF8001};
        tbl[4]  = '{1, 1, 0, 3'd2, 32'h1000,      32'h0,         5'd9,  1, 32'h0,        32'hDEADBEEF,  3,  2'b11, 2'b00, 1, 32'hDEADBEEF};
        tbl[5]  = '{1, 0, 1, 3'd2, 32'h20,        32'hCAFEBABE,  5'd10, 1, 32'h0,        32'h0,         4,  2'b00, 2'b11, 0, 32'h0};
        tbl[6]  = '{1, 0, 1, 3'd0, 32'h1ABCD,     32'h55,        5'd11, 1, 32'h0,        32'h0,         1,  2'b00, 2'b01, 0, 32'h0};
        tbl[7]  = '{1, 1, 0, 3'd2, 32'hFFFFFFFC,  32'h0,         5'd12, 1, 32'h0,        32'h7FFFFFFF,  1,  2'b11, 2'b00, 1, 32'h7FFFFFFF};
        tbl[8]  = '{1, 1, 0, 3'd5, 32'h40,        32'h0,         5'd13, 1, 32'h0,        32'hFFFF,      2,  2'b10, 2'b00, 1, 32'h0000FFFF};
        tbl[9]  = '{1, 1, 0, 3'd1, 32'h42,        32'h0,         5'd14, 1, 32'h0,        32'h7FFF,      1,  2'b10, 2'b00, 1, 32'h00007FFF};
        tbl[10] = '{1, 1, 0, 3'd3, 32'h80,        32'h0,         5'd15, 1, 32'h0,        32'h80000001,  2,  2'b11, 2'b00, 1, 32'h80000001};
        tbl[11] = '{1, 1, 1, 3'd0, 32'h90,        32'h1,         5'd16, 1, 32'h0,        32'h80,        1,  2'b01, 2'b00, 1, 32'hFFFFFF80};
        tbl[12] = '{0, 1, 0, 3'd0, 32'h90,        32'h0,         5'd17, 1, 32'h0,        32'h0,         1,  2'b00, 2'b00, 0, 32'h0};
        tbl[13] = '{1, 0, 0, 3'd0, 32'h0,         32'h0,         5'd0,  0, 32'hFFFFFFFF, 32'h0,         1,  2'b00, 2'b00, 0, 32'hFFFFFFFF};
        tbl[14] = '{1, 0, 1, 3'd1, 32'h1FFFE,     32'hFFFF1234,  5'd18, 1, 32'h0,        32'h0,         3,  2'b00, 2'b10, 0, 32'h0};

        f3s_ld = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        f3s_st = '{3'd0, 3'd1, 3'd2};

        // Reset held for two cycles with a non-memory op presented.
        rst = 1'b1;
        mem_data_enable = 1'b0; mem_data_i = 32'h0;
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'd0;
        ex_addr = 32'h0; ex_store_data = 32'h0; ex_rd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'hAAAA;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
            chk("rst_wb_rd", {27'h0, wb_rd}, 32'h0);
            chk("rst_wb_wreg", {31'h0, wb_wreg}, 32'h0);
            chk("rst_wb_wdata", wb_wdata, 32'h0);
            chk("rst_reqs", {28'h0, mem_read_req, mem_write_req}, 32'h0);
            chk("rst_addr", {15'h0, mem_addr}, 32'h0);
            chk("rst_wdata", mem_write_data, 32'h0);
            chk("rst_stall", {31'h0, stall_req}, 32'h0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_wb_valid", {31'h0, wb_valid}, 32'h1);
        chk("post_rst_wb_rd", {27'h0, wb_rd}, 32'd3);
        chk("post_rst_wb_wdata", wb_wdata, 32'hAAAA);

        // Directed table, applied back to back.
        for (int i = 0; i < 15; i++) do_op(tbl[i]);

        // Randomized ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            r.valid = 1'b1;
            r.ld = (kind == 1);
            r.st = (kind == 2);
            r.f3 = (kind == 2) ? f3s_st[$urandom_range(0, 2)] : f3s_ld[$urandom_range(0, 5)];
            r.addr = $urandom; r.sdata = $urandom; r.rd = 5'($urandom_range(0, 31));
            r.wreg = 1'($urandom_range(0, 1)); r.alu = $urandom;
            r.rdata = $urandom;
            // The buffer returns zero-extended data sized to the access.
            if (r.f3[1:0] == 2'd0) r.rdata = r.rdata % 256;
            else if (r.f3[1:0] == 2'd1) r.rdata = r.rdata % 65536;
            r.lat = $urandom_range(1, 4);
            r.e_rreq = r.ld ? model_width(r.f3) : 2'b00;
            r.e_wreq = r.st ? model_width(r.f3) : 2'b00;
            r.e_wreg = r.st ? 1'b0 : r.wreg;
            r.e_wdata = r.ld ? model_load(r.f3, r.rdata) : r.alu;
            do_op(r);
        end

        // Reset while an access is in flight abandons it.
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'd2;
        ex_addr = 32'h300; ex_rd = 5'd20; ex_wreg = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req_issued", {30'h0, mem_read_req}, 32'h3);
        rst = 1'b1;
        ex_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_reqs_clear", {28'h0, mem_read_req, mem_write_req}, 32'h0);
        chk("midrst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("midrst_addr", {15'h0, mem_addr}, 32'h0);
        rst = 1'b0;
        do_op(tbl[3]);
        do_op(tbl[0]);

        ex_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_wb_valid", {31'h0, wb_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
